ibex_mem_responder: RTL and testbench

IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

---
 rtl/ibex_mem_responder.sv | 138 +++++++++++++
 tb/tb_ibex_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_responder.sv
// Ibex-style data memory responder: 2-deep in-order request queue, fixed wait states.
// Define IBEX_MEM_RESP_ERR_EN to report out-of-range accesses on err_o.
module ibex_mem_responder #(
  parameter logic [31:0] BaseAddr   = 32'h8000_0000,
  parameter int unsigned MemWords   = 1024,
  parameter int unsigned WaitStates = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(MemWords);
  localparam logic [2:0] WS = 3'(WaitStates);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          rng;
  } ent_t;

  ent_t        r_fifo [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_cnt;
  logic [1:0]  r_state;
  logic [2:0]  r_wait;
  logic [31:0] r_mem [MemWords];

  logic [29:0] w_word;
  logic        w_rng;
  logic        w_gnt;
  logic        w_rvalid;
  logic [1:0]  w_cnt_nx;
  logic [1:0]  w_state_nx;
  logic [2:0]  w_wait_nx;
  ent_t        w_new;
  ent_t        w_head;
  logic [31:0] w_rd;

  // Offset arithmetic keeps the range test correct even near 4 GiB wrap.
  assign w_word = 30'((addr_i - BaseAddr) >> 2);
  assign w_rng  = (addr_i >= BaseAddr) && (w_word[29:AW] == '0);

  assign w_new.idx   = w_word[AW-1:0];
  assign w_new.we    = we_i;
  assign w_new.be    = be_i;
  assign w_new.wdata = wdata_i;
  assign w_new.rng   = w_rng;

  assign w_gnt    = req_i && (r_cnt != 2'd2) && !rst;
  assign w_rvalid = (r_state == S_RESP) && !rst;
  assign w_head   = r_fifo[r_rptr];
  assign w_rd     = r_mem[w_head.idx];
  assign w_cnt_nx = r_cnt + {1'b0, w_gnt} - {1'b0, w_rvalid};

  always_comb begin
    w_state_nx = r_state;
    w_wait_nx  = r_wait;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_wait_nx  = WS;
          w_state_nx = (WS == 3'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_wait_nx = r_wait - 3'd1;
        if (r_wait == 3'd1) w_state_nx = S_RESP;
      end
      S_RESP: begin
        if (w_cnt_nx != 2'd0) begin
          w_wait_nx  = WS;
          w_state_nx = (WS == 3'd0) ? S_RESP : S_WAIT;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_cnt   <= 2'd0;
      r_state <= S_IDLE;
      r_wait  <= 3'd0;
    end else begin
      if (w_gnt) r_wptr <= ~r_wptr;
      if (w_rvalid) r_rptr <= ~r_rptr;
      r_cnt   <= w_cnt_nx;
      r_state <= w_state_nx;
      r_wait  <= w_wait_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt) r_fifo[r_wptr] <= w_new;
  end

  // Writes commit at their own response edge, so later reads see them.
  always_ff @(posedge clk) begin
    if (w_rvalid && w_head.we && w_head.rng) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head.be[b]) r_mem[w_head.idx][8*b +: 8] <= w_head.wdata[8*b +: 8];
      end
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = w_rvalid;
  assign busy_o   = (r_cnt != 2'd0);
  assign rdata_o  = (w_rvalid && !w_head.we && w_head.rng) ? w_rd : 32'h0;

`ifdef IBEX_MEM_RESP_ERR_EN
  assign err_o = w_rvalid && !w_head.rng;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: two instances (0 and 3 wait states),
// in-order scoreboard with a reference memory evaluated at response time.
module tb_ibex_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam int MW0 = 1024;
  localparam int MW1 = 16;
`ifdef IBEX_MEM_RESP_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic        gnt   [2];
  logic        rv    [2];
  logic        err   [2];
  logic        busy  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  be    [2];

  ibex_mem_responder #(
    .BaseAddr(BASE), .MemWords(MW0), .WaitStates(WS0)
  ) u0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .rvalid_o(rv[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .busy_o(busy[0])
  );

  ibex_mem_responder #(
    .BaseAddr(BASE), .MemWords(MW1), .WaitStates(WS1)
  ) u1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .rvalid_o(rv[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .busy_o(busy[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          due;
  } req_t;

  req_t        q0[$];
  req_t        q1[$];
  logic [31:0] mm [int];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ld [2];
  bit          chk_on = 0;
  logic [31:0] last_rd [2];
  logic        last_err [2];
  bit          last_gnt [2];
  int          rv_cnt [2];
  int          rv_cyc1[$];
  int          gnt_cyc1[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(int d, logic [31:0] a);
    int mw;
    mw = (d == 0) ? MW0 : MW1;
    return (a >= BASE) && ((a - BASE) < 32'(4 * mw));
  endfunction

  function automatic int key(int d, logic [31:0] a);
    return d * 1000000 + int'((a - BASE) >> 2);
  endfunction

  task automatic check_dut(int d);
    req_t        h;
    int          sz;
    int          ws;
    int          due;
    int          k;
    logic        eg;
    logic        erv;
    logic        inr;
    logic [31:0] ed;
    logic [31:0] w;
    sz  = (d == 0) ? q0.size() : q1.size();
    ws  = (d == 0) ? WS0 : WS1;
    eg  = req[d] && (sz < 2) && !rst;
    erv = 1'b0;
    chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(eg));
    chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(sz != 0));
    if (sz > 0) begin
      h   = (d == 0) ? q0[0] : q1[0];
      erv = !rst && (h.due == cyc);
    end
    chk($sformatf("rvalid%0d", d), 32'(rv[d]), 32'(erv));
    if (erv) begin
      if (d == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      inr = in_rng(d, h.addr);
      k   = key(d, h.addr);
      ed  = 32'h0;
      if (inr && !h.we) ed = mm.exists(k) ? mm[k] : 'x;
      if (inr && h.we) begin
        w = mm.exists(k) ? mm[k] : 'x;
        for (int b = 0; b < 4; b++)
          if (h.be[b]) w[8*b +: 8] = h.wdata[8*b +: 8];
        mm[k] = w;
      end
      chk($sformatf("rdata%0d", d), rdata[d], ed);
      chk($sformatf("err%0d", d), 32'(err[d]), 32'(ERR && !inr));
      last_rd[d]  = rdata[d];
      last_err[d] = err[d];
      rv_cnt[d]++;
      if (d == 1) rv_cyc1.push_back(cyc);
    end else begin
      chk($sformatf("idle_rdata%0d", d), rdata[d], 32'h0);
      chk($sformatf("idle_err%0d", d), 32'(err[d]), 32'h0);
    end
    if (rst) begin
      if (d == 0) q0.delete();
      else q1.delete();
      ld[d] = -100;
    end else if (eg) begin
      due   = (cyc + 1 + ws > ld[d] + 1 + ws) ? cyc + 1 + ws : ld[d] + 1 + ws;
      ld[d] = due;
      h     = '{addr[d], we[d], be[d], wdata[d], due};
      if (d == 0) q0.push_back(h);
      else q1.push_back(h);
      if (d == 1) gnt_cyc1.push_back(cyc);
    end
    last_gnt[d] = eg;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_on) begin
      check_dut(0);
      check_dut(1);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic put(int d, logic r, logic w, logic [31:0] a,
                     logic [3:0] b, logic [31:0] dat);
    req[d]   = r;
    we[d]    = w;
    addr[d]  = a;
    be[d]    = b;
    wdata[d] = dat;
  endtask

  task automatic idle(int d);
    put(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n && (q0.size() + q1.size()) != 0; i++) cycle();
    chk("drain", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  // Holds a request on instance 1 until the model sees it granted.
  task automatic issue(logic w, logic [31:0] a, logic [3:0] b,
                       logic [31:0] dat);
    bit g;
    g = 0;
    put(1, 1'b1, w, a, b, dat);
    for (int i = 0; i < 20 && !g; i++) begin
      cycle();
      g = last_gnt[1];
    end
    chk("issue_gnt", 32'(g), 32'h1);
  endtask

  initial begin
    int t0;
    int n;
    int k;
    ld[0] = -100;
    ld[1] = -100;
    rv_cnt[0] = 0;
    rv_cnt[1] = 0;
    rst = 1'b1;
    idle(0);
    idle(1);
    cycle();
    chk_on = 1;
    put(0, 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    cycle();
    rst = 1'b0;

    put(0, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    cycle();
    put(0, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
    cycle();
    idle(0);
    drain(10);
    chk("rd_deadbeef", last_rd[0], 32'hDEAD_BEEF);

    put(0, 1'b1, 1'b1, 32'h8000_0020, 4'hF, 32'hFFFF_FFFF);
    cycle();
    put(0, 1'b1, 1'b1, 32'h8000_0020, 4'b0101, 32'h1122_3344);
    cycle();
    put(0, 1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    cycle();
    idle(0);
    drain(10);
    chk("rd_masked", last_rd[0], 32'hFF22_FF44);

    put(0, 1'b1, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
    cycle();
    idle(0);
    drain(10);
    chk("oor_rdata", last_rd[0], 32'h0);
    chk("oor_err", 32'(last_err[0]), 32'(ERR));

    n = rv_cnt[0];
    for (int i = 0; i < 16; i++) begin
      put(0, 1'b1, 1'b1, BASE + 32'h100 + 32'(4 * i), 4'hF,
          32'hA000_0000 ^ (32'(i) * 32'h0101_0101));
      cycle();
    end
    for (int i = 0; i < 16; i++) begin
      put(0, 1'b1, 1'b0, BASE + 32'h100 + 32'(4 * i), 4'h0, 32'h0);
      cycle();
    end
    idle(0);
    drain(10);
    chk("b2b_count", 32'(rv_cnt[0] - n), 32'd32);

    t0 = cyc;
    k  = 0;
    gnt_cyc1.delete();
    rv_cyc1.delete();
    for (int i = 0; i < 40 && k < 3; i++) begin
      put(1, 1'b1, 1'b1, BASE + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k));
      cycle();
      if (last_gnt[1]) k++;
    end
    chk("ws3_grants", 32'(k), 32'd3);
    idle(1);
    drain(40);
    if (gnt_cyc1.size() == 3 && rv_cyc1.size() == 3) begin
      chk("ws3_gnt0", 32'(gnt_cyc1[0] - t0), 32'd0);
      chk("ws3_gnt1", 32'(gnt_cyc1[1] - t0), 32'd1);
      chk("ws3_gnt2", 32'(gnt_cyc1[2] - t0), 32'd5);
      chk("ws3_rv0", 32'(rv_cyc1[0] - t0), 32'd4);
      chk("ws3_rv1", 32'(rv_cyc1[1] - t0), 32'd8);
      chk("ws3_rv2", 32'(rv_cyc1[2] - t0), 32'd12);
    end else begin
      chk("ws3_log", 32'(gnt_cyc1.size() + rv_cyc1.size()), 32'd6);
    end

    issue(1'b0, BASE + 32'h4, 4'h0, 32'h0);
    issue(1'b1, BASE + 32'h3C, 4'hF, 32'h5A5A_0F0F);
    issue(1'b0, BASE + 32'h3C, 4'h0, 32'h0);
    idle(1);
    drain(40);
    chk("last_word", last_rd[1], 32'h5A5A_0F0F);
    issue(1'b1, BASE + 32'h40, 4'hF, 32'hBAD0_BAD0);
    issue(1'b0, BASE + 32'h40, 4'h0, 32'h0);
    idle(1);
    drain(40);
    chk("past_end_rdata", last_rd[1], 32'h0);
    chk("past_end_err", 32'(last_err[1]), 32'(ERR));
    issue(1'b0, BASE, 4'h0, 32'h0);
    idle(1);
    drain(40);
    chk("no_wrap_write", last_rd[1], 32'hC0DE_0000);

    issue(1'b1, BASE + 32'h14, 4'hF, 32'hA5A5_A5A5);
    idle(1);
    drain(40);
    issue(1'b1, BASE + 32'h14, 4'hF, 32'h1234_5678);
    issue(1'b0, BASE + 32'h14, 4'h0, 32'h0);
    idle(1);
    n = rv_cnt[1];
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    chk("rst_drop", 32'(rv_cnt[1] - n), 32'h0);
    issue(1'b0, BASE + 32'h14, 4'h0, 32'h0);
    idle(1);
    drain(40);
    chk("rst_mem_kept", last_rd[1], 32'hA5A5_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
